// File: rtl/song_player_ctrl_pkg.sv
// Shared types and widths for the song player controller and its note/gap timer.
package song_player_ctrl_pkg;

   localparam int SONG_LEN_DEF = 26;
   localparam int NOTE_W       = 4;
   localparam int DUR_W        = 26;
   localparam int LOC_W        = 5;
   localparam int SONG_W       = 2;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_FETCH = 3'd1,
      S_LOAD  = 3'd2,
      S_PLAY  = 3'd3,
      S_GAP   = 3'd4,
      S_DONE  = 3'd5
   } state_t;

endpackage

// File: rtl/song_player_ctrl_play_timer.sv
// Loadable down-counter shared by note playback and the inter-note gap.
// Load wins over decrement; the counter never wraps below zero.
module play_timer
   import song_player_ctrl_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [DUR_W-1:0] load_val,
   input  logic             dec,
   output logic             last
);

   logic [DUR_W-1:0] count;

   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (dec && (count != '0)) begin
         count <= count - DUR_W'(1);
      end
   end

   assign last = (count == DUR_W'(1));

endmodule

// File: rtl/song_player_ctrl.sv
// Song playback sequencer: fetches each note from song memory, sounds it for its
// duration, inserts a silent gap, and pulses song_done after the last location.
module song_player_ctrl
   import song_player_ctrl_pkg::*;
#(
   parameter int SONG_LEN   = SONG_LEN_DEF,
   parameter int GAP_CYCLES = 2500000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [SONG_W-1:0] songnum_in,
   input  logic              pause,
   input  logic              stop,
   output logic              mem_isread,
   output logic [SONG_W-1:0] mem_songnum,
   output logic [LOC_W-1:0]  mem_location,
   input  logic [NOTE_W-1:0] mem_note,
   input  logic [DUR_W-1:0]  mem_duration,
   output logic [NOTE_W-1:0] note_out,
   output logic              note_valid,
   output logic              busy,
   output logic              song_done
);

   localparam logic [DUR_W-1:0] GAP_VAL  = DUR_W'(GAP_CYCLES);
   localparam logic [LOC_W-1:0] LAST_LOC = LOC_W'(SONG_LEN - 1);

   state_t            state;
   logic [LOC_W-1:0]  idx;
   logic [SONG_W-1:0] songnum_q;
   logic [NOTE_W-1:0] note_q;

   logic             tmr_load;
   logic             tmr_dec;
   logic             tmr_last;
   logic [DUR_W-1:0] tmr_val;
   logic             dur_zero;
   logic             play_end;
   logic             gap_end;

   assign dur_zero = (mem_duration == '0);

   // A zero-length gap collapses into the end of the note, so the next fetch
   // (or DONE) follows the last PLAY cycle directly.
   always_comb begin
      play_end = 1'b0;
      gap_end  = 1'b0;
      tmr_load = 1'b0;
      tmr_val  = GAP_VAL;
      tmr_dec  = !pause && ((state == S_PLAY) || (state == S_GAP));
      case (state)
         S_LOAD: begin
            tmr_load = 1'b1;
            if (dur_zero) begin
               play_end = 1'b1;
            end else begin
               tmr_val = mem_duration;
            end
         end
         S_PLAY: begin
            if (!pause && tmr_last) begin
               play_end = 1'b1;
               tmr_load = 1'b1;
            end
         end
         S_GAP: gap_end = !pause && tmr_last;
         default: ;
      endcase
      if (play_end && (GAP_CYCLES == 0)) begin
         gap_end = 1'b1;
      end
   end

   play_timer u_timer (
      .clk      (clk),
      .rst      (rst),
      .load     (tmr_load),
      .load_val (tmr_val),
      .dec      (tmr_dec),
      .last     (tmr_last)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         idx       <= '0;
         songnum_q <= '0;
         note_q    <= '0;
      end else if (stop) begin
         state <= S_IDLE;
      end else begin
         case (state)
            S_IDLE: begin
               if (start && (songnum_in != '0)) begin
                  songnum_q <= songnum_in;
                  idx       <= '0;
                  state     <= S_FETCH;
               end
            end
            S_FETCH: state <= S_LOAD;
            S_LOAD: begin
               note_q <= mem_note;
               state  <= dur_zero ? S_GAP : S_PLAY;
            end
            S_PLAY: begin
               if (play_end) begin
                  state <= S_GAP;
               end
            end
            S_GAP:  ;
            S_DONE: state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
         // End of gap overrides the per-state transition above.
         if (gap_end) begin
            if (idx == LAST_LOC) begin
               state <= S_DONE;
            end else begin
               idx   <= idx + LOC_W'(1);
               state <= S_FETCH;
            end
         end
      end
   end

   assign busy         = (state != S_IDLE);
   assign mem_isread   = (state == S_FETCH) || (state == S_LOAD);
   assign song_done    = (state == S_DONE);
   assign note_valid   = (state == S_PLAY) && !pause;
   assign note_out     = note_q;
   assign mem_songnum  = songnum_q;
   assign mem_location = idx;

endmodule

// File: tb/tb_song_player_ctrl.sv
// Bench for song_player_ctrl: registered-read song memory plus a phase-queue
// reference model of playback (fetch, load, play, gap, done).
module tb_song_player_ctrl;

   localparam int SL  = 4;
   localparam int GAP = 2;
   localparam int K_FETCH = 0, K_LOAD = 1, K_PLAY = 2, K_GAP = 3, K_DONE = 4;

   typedef struct {
      int kind;
      int len;
      int loc;
   } phase_t;

   logic        clk = 1'b0;
   logic        rst, start, pause, stop;
   logic [1:0]  songnum_in;
   logic        mem_isread;
   logic [1:0]  mem_songnum;
   logic [4:0]  mem_location;
   logic [3:0]  mem_note;
   logic [25:0] mem_duration;
   logic [3:0]  note_out;
   logic        note_valid, busy, song_done;

   int checks = 0;
   int errors = 0;
   int notes[4][SL];
   int durs[4][SL];
   phase_t ph[$];

   song_player_ctrl #(.SONG_LEN(SL), .GAP_CYCLES(GAP)) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .songnum_in   (songnum_in),
      .pause        (pause),
      .stop         (stop),
      .mem_isread   (mem_isread),
      .mem_songnum  (mem_songnum),
      .mem_location (mem_location),
      .mem_note     (mem_note),
      .mem_duration (mem_duration),
      .note_out     (note_out),
      .note_valid   (note_valid),
      .busy         (busy),
      .song_done    (song_done)
   );

   always #5 clk = ~clk;

   // Song memory with one-cycle registered read.
   always @(posedge clk) begin
      if (mem_isread && (mem_location < SL)) begin
         mem_note     <= 4'(notes[mem_songnum][mem_location]);
         mem_duration <= 26'(durs[mem_songnum][mem_location]);
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic check_reset(input string t);
      check({t, "_note_out"},     note_out,     0);
      check({t, "_note_valid"},   note_valid,   0);
      check({t, "_busy"},         busy,         0);
      check({t, "_song_done"},    song_done,    0);
      check({t, "_mem_isread"},   mem_isread,   0);
      check({t, "_mem_songnum"},  mem_songnum,  0);
      check({t, "_mem_location"}, mem_location, 0);
   endtask

   // Expected playback as a list of phases; pausable phases only consume unpaused cycles.
   function automatic void build(input int s);
      ph.delete();
      for (int l = 0; l < SL; l++) begin
         ph.push_back('{K_FETCH, 1, l});
         ph.push_back('{K_LOAD, 1, l});
         if (durs[s][l] != 0) ph.push_back('{K_PLAY, durs[s][l], l});
         if (GAP > 0) ph.push_back('{K_GAP, GAP, l});
      end
      ph.push_back('{K_DONE, 1, SL - 1});
   endfunction

   // pmode: 0 no pause, 1 random pause and spurious starts, 2 five-cycle pause
   // from the 2nd PLAY cycle of note 0. stop_loc/rst_loc < 0 disable the abort.
   task automatic run_song(input int s, input int pmode, input int stop_loc, input int rst_loc);
      phase_t cur;
      int budget = 0;
      int pleft = 0;
      bit pdone = 0;
      bit aborted = 0;
      bit pausable;
      int obs_v[SL];
      for (int l = 0; l < SL; l++) obs_v[l] = 0;
      build(s);
      @(negedge clk);
      start = 1'b1;
      songnum_in = 2'(s);
      @(negedge clk);
      start = 1'b0;
      while ((ph.size() > 0) && (budget < 1000)) begin
         cur = ph[0];
         pause = 1'b0;
         start = 1'b0;
         if (pmode == 1) begin
            pause = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 7) == 0) begin
               start = 1'b1;
               songnum_in = 2'($urandom_range(0, 3));
            end
         end else if (pmode == 2) begin
            if (pleft > 0) begin
               pause = 1'b1;
               pleft--;
            end else if (!pdone && cur.kind == K_PLAY && cur.loc == 0 && cur.len == durs[s][0] - 1) begin
               pause = 1'b1;
               pleft = 4;
               pdone = 1'b1;
            end
         end
         if (cur.kind == K_PLAY && cur.loc == stop_loc) begin
            stop = 1'b1;
            start = 1'b1;
            pause = 1'b0;
            @(negedge clk);
            stop = 1'b0;
            start = 1'b0;
            #1;
            check("stop_busy", busy, 0);
            check("stop_note_valid", note_valid, 0);
            check("stop_song_done", song_done, 0);
            repeat (3) begin
               @(negedge clk);
               #1;
               check("stop_stays_idle", busy, 0);
               check("stop_no_done", song_done, 0);
            end
            aborted = 1'b1;
            break;
         end
         if (cur.kind == K_GAP && cur.loc == rst_loc) begin
            rst = 1'b1;
            start = 1'b1;
            songnum_in = 2'd3;
            pause = 1'b0;
            @(negedge clk);
            start = 1'b0;
            #1;
            check_reset("rst_gap");
            rst = 1'b0;
            aborted = 1'b1;
            break;
         end
         #1;
         check("busy", busy, 1);
         check("note_valid", note_valid, (cur.kind == K_PLAY) && !pause);
         check("mem_isread", mem_isread, (cur.kind == K_FETCH) || (cur.kind == K_LOAD));
         check("song_done", song_done, cur.kind == K_DONE);
         check("mem_songnum", mem_songnum, s);
         check("mem_location", mem_location, cur.loc);
         if (cur.kind == K_PLAY) check("note_out", note_out, notes[s][cur.loc]);
         if (note_valid === 1'b1) obs_v[cur.loc]++;
         pausable = (cur.kind == K_PLAY) || (cur.kind == K_GAP);
         if (!(pausable && pause)) begin
            ph[0].len = ph[0].len - 1;
            if (ph[0].len == 0) void'(ph.pop_front());
         end
         @(negedge clk);
         budget++;
      end
      pause = 1'b0;
      start = 1'b0;
      if (!aborted) begin
         check("finished_in_budget", ph.size(), 0);
         #1;
         check("end_busy", busy, 0);
         check("end_song_done", song_done, 0);
         for (int l = 0; l < SL; l++) check("note_valid_cycles", obs_v[l], durs[s][l]);
      end
   endtask

   initial begin
      rst = 1'b1;
      start = 1'b0;
      pause = 1'b0;
      stop = 1'b0;
      songnum_in = 2'd0;
      notes[0] = '{0, 0, 0, 0};
      durs[0]  = '{0, 0, 0, 0};
      notes[1] = '{2, 2, 3, 4};
      durs[1]  = '{3, 3, 3, 3};
      notes[2] = '{5, 6, 7, 8};
      durs[2]  = '{3, 2, 1, 2};
      notes[3] = '{9, 10, 11, 12};
      durs[3]  = '{2, 0, 3, 1};
      repeat (3) @(negedge clk);
      #1;
      check_reset("por");
      rst = 1'b0;

      run_song(1, 0, -1, -1);

      @(negedge clk);
      start = 1'b1;
      songnum_in = 2'd0;
      @(negedge clk);
      start = 1'b0;
      repeat (6) begin
         #1;
         check("invalid_song_busy", busy, 0);
         check("invalid_song_isread", mem_isread, 0);
         @(negedge clk);
      end

      run_song(2, 2, -1, -1);
      run_song(3, 0, -1, -1);
      run_song(1, 0, 2, -1);
      run_song(1, 0, -1, -1);
      run_song(2, 0, -1, 1);
      run_song(2, 0, -1, -1);

      repeat (6) begin
         for (int s = 1; s < 4; s++) begin
            for (int l = 0; l < SL; l++) begin
               notes[s][l] = $urandom_range(0, 15);
               durs[s][l]  = $urandom_range(0, 4);
            end
         end
         run_song($urandom_range(1, 3), 1, -1, -1);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
